// File: rtl/servo_pkg.sv
// Shared constants and elaboration helpers for the servo PWM bank.
// The optional slew limiter is enabled by defining SERVO_SLEW_EN.
package servo_pkg;

    localparam int ENDCOUNT_50HZ  = 2559;
    localparam int MIN_PULSE_0MS5 = 64;
    localparam int SLEW_STEP      = 4;
    localparam int CHAN_SEL_W     = 4;

    // True when a counter of cnt_w bits can reach endcount.
    function automatic bit count_fits(input int endcount, input int cnt_w);
        return endcount < (1 << cnt_w);
    endfunction

    // True when the longest pulse still ends inside the period.
    function automatic bit pulse_fits(input int min_pulse, input int duty_w, input int endcount);
        return (min_pulse + (1 << duty_w) - 1) <= endcount;
    endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo channel: shadow/active duty registers, optional slew limiter
// (SERVO_SLEW_EN) and the registered pulse compare.
module servo_pwm_chan
    import servo_pkg::*;
#(
    parameter int DUTY_W    = 8,
    parameter int CNT_W     = 12,
    parameter int MIN_PULSE = MIN_PULSE_0MS5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DUTY_W-1:0] wr_duty_i,
    input  logic              boundary_i,
    input  logic              arm_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic              pwm_o,
    output logic              settled_o
);

    logic [DUTY_W-1:0] shadow_q, shadow_d;
    logic [DUTY_W-1:0] active_q, active_d;
    logic [CNT_W:0]    thresh;
    logic              pwm_q, pwm_d;
    logic              commit;

    assign commit = boundary_i & arm_i;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i) begin
            shadow_d = wr_duty_i;
        end
    end

`ifdef SERVO_SLEW_EN
    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(SLEW_STEP);

    logic [DUTY_W-1:0] target_q, target_d;

    // The step taken at a commit boundary already heads for the new target.
    always_comb begin
        target_d = commit ? shadow_q : target_q;
        active_d = active_q;
        if (boundary_i) begin
            if (active_q < target_d) begin
                active_d = ((target_d - active_q) > STEP) ? (active_q + STEP) : target_d;
            end else if (active_q > target_d) begin
                active_d = ((active_q - target_d) > STEP) ? (active_q - STEP) : target_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= '0;
        end else begin
            target_q <= target_d;
        end
    end

    assign settled_o = (active_q == target_q);
`else
    always_comb begin
        active_d = active_q;
        if (commit) begin
            active_d = shadow_q;
        end
    end

    assign settled_o = 1'b1;
`endif

    // One extra bit so MIN_PULSE + duty never wraps.
    assign thresh = (CNT_W+1)'(MIN_PULSE) + (CNT_W+1)'(active_q);
    assign pwm_d  = ({1'b0, count_i} < thresh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM bank: shared period counter, synchronised latch
// strobe and boundary-aligned duty commit. Slew limiting via SERVO_SLEW_EN.
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int DUTY_W    = 8,
    parameter int CNT_W     = 12,
    parameter int ENDCOUNT  = ENDCOUNT_50HZ,
    parameter int MIN_PULSE = MIN_PULSE_0MS5
) (
    input  logic                  clockdiv,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [CHAN_SEL_W-1:0] wr_chan,
    input  logic [DUTY_W-1:0]     wr_duty,
    input  logic                  latch,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_start,
    output logic                  update_pending
);

    if (!pulse_fits(MIN_PULSE, DUTY_W, ENDCOUNT)) begin : g_bad_pulse
        $error("servo_pwm_bank: MIN_PULSE + 2**DUTY_W - 1 exceeds ENDCOUNT");
    end
    if (!count_fits(ENDCOUNT, CNT_W)) begin : g_bad_count
        $error("servo_pwm_bank: CNT_W too narrow for ENDCOUNT");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_chan
        $error("servo_pwm_bank: CHANNELS must be 1..16");
    end

    logic [CNT_W-1:0]    counter_q, counter_d;
    logic                start_q, start_d;
    logic                latch_meta_q, latch_sync_q, latch_prev_q;
    logic                pending_q, pending_d;
    logic                rise, boundary, arm;
    logic [CHANNELS-1:0] settled;

    assign boundary = (counter_q == CNT_W'(ENDCOUNT));
    assign rise     = latch_sync_q & ~latch_prev_q;
    assign arm      = pending_q | rise;

    always_comb begin
        counter_d = boundary ? '0 : counter_q + 1'b1;
        start_d   = (counter_q == '0);
        pending_d = pending_q;
        // A rise seen in the commit cycle is consumed by that commit.
        if (boundary && arm) begin
            pending_d = 1'b0;
        end else if (rise) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clockdiv or posedge reset) begin
        if (reset) begin
            counter_q    <= '0;
            start_q      <= 1'b0;
            latch_meta_q <= 1'b0;
            latch_sync_q <= 1'b0;
            latch_prev_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            counter_q    <= counter_d;
            start_q      <= start_d;
            latch_meta_q <= latch;
            latch_sync_q <= latch_meta_q;
            latch_prev_q <= latch_sync_q;
            pending_q    <= pending_d;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        servo_pwm_chan #(
            .DUTY_W    (DUTY_W),
            .CNT_W     (CNT_W),
            .MIN_PULSE (MIN_PULSE)
        ) u_chan (
            .clk        (clockdiv),
            .rst        (reset),
            .wr_en_i    (wr_en && (wr_chan == CHAN_SEL_W'(gi))),
            .wr_duty_i  (wr_duty),
            .boundary_i (boundary),
            .arm_i      (arm),
            .count_i    (counter_q),
            .pwm_o      (pwm_out[gi]),
            .settled_o  (settled[gi])
        );
    end

    assign period_start   = start_q;
    assign update_pending = pending_q | ~(&settled);

endmodule
